// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MULTU/DIVU sequencer driving the shared ALU, owns HI/LO
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_control,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {S_IDLE, S_STEP_A, S_STEP_B, S_DONE} state_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLTU = 3'b100;

    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic        ge_q, ge_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [31:0] p_hi_q, p_hi_d;
    logic [31:0] p_lo_q, p_lo_d;
    logic [31:0] t_q, t_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] p_hi_nxt, p_lo_nxt;
    logic [31:0] rs;

    // Partial remainder shifted left by one, with its lost top bit kept as P_hi[31]
    assign rs = {p_hi_q[30:0], p_lo_q[31]};

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ge_d        = ge_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        dvsr_d      = dvsr_q;
        p_hi_d      = p_hi_q;
        p_lo_d      = p_lo_q;
        t_d         = t_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        p_hi_nxt    = p_hi_q;
        p_lo_nxt    = p_lo_q;
        alu_a       = 32'd0;
        alu_b       = 32'd0;
        alu_control = ALU_ADD;
        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start && !cancel) begin
                    op_d    = op;
                    mcand_d = src_a;
                    p_hi_d  = 32'd0;
                    p_lo_d  = op ? src_a : src_b;
                    dvsr_d  = src_b;
                    cnt_d   = 5'd0;
                    state_d = S_STEP_A;
                end
            end
            S_STEP_A: begin
                if (!op_q) begin
                    alu_a = p_hi_q;
                    alu_b = p_lo_q[0] ? mcand_q : 32'd0;
                    t_d   = alu_result;
                end else begin
                    alu_a       = rs;
                    alu_b       = dvsr_q;
                    alu_control = ALU_SLTU;
                    ge_d        = p_hi_q[31] | ~alu_result[0];
                end
                state_d = cancel ? S_IDLE : S_STEP_B;
            end
            S_STEP_B: begin
                if (!op_q) begin
                    // Sum smaller than an addend means the add carried out
                    alu_a       = t_q;
                    alu_b       = p_hi_q;
                    alu_control = ALU_SLTU;
                    p_hi_nxt    = {alu_result[0], t_q[31:1]};
                    p_lo_nxt    = {t_q[0], p_lo_q[31:1]};
                end else begin
                    alu_a       = rs;
                    alu_b       = ge_q ? dvsr_q : 32'd0;
                    alu_control = ALU_SUB;
                    p_hi_nxt    = alu_result;
                    p_lo_nxt    = {p_lo_q[30:0], ge_q};
                end
                p_hi_d = p_hi_nxt;
                p_lo_d = p_lo_nxt;
                cnt_d  = cnt_q + 5'd1;
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 5'd31) begin
                    hi_d    = p_hi_nxt;
                    lo_d    = p_lo_nxt;
                    state_d = S_DONE;
                end else begin
                    state_d = S_STEP_A;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            ge_q    <= 1'b0;
            cnt_q   <= 5'd0;
            mcand_q <= 32'd0;
            dvsr_q  <= 32'd0;
            p_hi_q  <= 32'd0;
            p_lo_q  <= 32'd0;
            t_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ge_q    <= ge_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            dvsr_q  <= dvsr_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            t_q     <= t_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_STEP_A) || (state_q == S_STEP_B);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized and directed checks of muldiv_seq against arithmetic reference
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst, start, op, cancel, hi_we, lo_we;
    logic [31:0] src_a, src_b, wdata;
    logic [31:0] alu_a, alu_b, alu_result, hi, lo;
    logic [2:0]  alu_control;
    logic        busy, done;
    int          total = 0;
    int          bad = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Shared pipeline ALU
    always_comb begin
        case (alu_control)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b100:  alu_result = {31'd0, alu_a < alu_b};
            default: alu_result = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_result(input logic o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        if (!o)          r = {32'd0, a} * {32'd0, b};
        else if (b == 0) r = {a, 32'hFFFFFFFF};
        else             r = {a % b, a / b};
        return r;
    endfunction

    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, input bit inject);
        logic [63:0] exp;
        exp = ref_result(o, a, b);
        start = 1'b1; op = o; src_a = a; src_b = b;
        step();
        start = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            check("busy_run", {63'd0, busy}, 64'd1);
            check("done_run", {63'd0, done}, 64'd0);
            if (inject && k == 20) begin
                start = 1'b1; op = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
            end
            step();
            start = 1'b0; lo_we = 1'b0;
        end
        check("done_c65", {63'd0, done}, 64'd1);
        check("busy_c65", {63'd0, busy}, 64'd0);
        check("hi_result", {32'd0, hi}, {32'd0, exp[63:32]});
        check("lo_result", {32'd0, lo}, {32'd0, exp[31:0]});
        mhi = exp[63:32];
        mlo = exp[31:0];
        step();
        check("done_c66", {63'd0, done}, 64'd0);
        check("busy_c66", {63'd0, busy}, 64'd0);
        check("alu_idle", {29'd0, alu_control, alu_a | alu_b}, 64'd0);
    endtask

    initial begin
        logic o;
        logic [31:0] a, b;
        rst = 1'b1; start = 1'b0; op = 1'b0; cancel = 1'b0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0; src_a = 32'd0; src_b = 32'd0;
        #1;
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy_done", {62'd0, busy, done}, 64'd0);
        step(); step();
        rst = 1'b0;
        step();

        hi_we = 1'b1; wdata = 32'h0BADF00D;
        step();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h13579BDF;
        step();
        lo_we = 1'b0;
        check("mthi", {32'd0, hi}, 64'h0BADF00D);
        check("mtlo", {32'd0, lo}, 64'h13579BDF);

        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(1'b1, 32'd100, 32'd7, 1'b0);
        run_op(1'b1, 32'h80000001, 32'h80000000, 1'b0);
        run_op(1'b1, 32'h12345678, 32'd0, 1'b0);

        // MTHI then MULTU 3x5 cancelled in cycle 10
        hi_we = 1'b1; wdata = 32'hAAAA5555;
        step();
        hi_we = 1'b0;
        mhi = 32'hAAAA5555;
        start = 1'b1; op = 1'b0; src_a = 32'd3; src_b = 32'd5;
        step();
        start = 1'b0;
        for (int k = 1; k < 10; k++) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("cancel_busy", {63'd0, busy}, 64'd0);
        for (int k = 0; k < 70; k++) begin
            check("cancel_no_done", {63'd0, done}, 64'd0);
            step();
        end
        check("cancel_hi", {32'd0, hi}, {32'd0, mhi});
        check("cancel_lo", {32'd0, lo}, {32'd0, mlo});

        // start and cancel together in IDLE
        start = 1'b1; cancel = 1'b1; op = 1'b0; src_a = 32'd9; src_b = 32'd9;
        step();
        start = 1'b0; cancel = 1'b0;
        check("start_cancel_busy", {63'd0, busy}, 64'd0);
        step();
        check("start_cancel_done", {62'd0, busy, done}, 64'd0);

        run_op(1'b0, 32'd6, 32'd7, 1'b1);

        // Reset in cycle 30 of a DIVU
        start = 1'b1; op = 1'b1; src_a = 32'd1000; src_b = 32'd3;
        step();
        start = 1'b0;
        for (int k = 1; k < 30; k++) step();
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        check("midrst_busy_done", {62'd0, busy, done}, 64'd0);
        mhi = 32'd0; mlo = 32'd0;
        step();
        rst = 1'b0;
        step();
        run_op(1'b0, 32'd2, 32'd3, 1'b0);

        for (int i = 0; i < 16; i++) begin
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            if (i % 5 == 4) a = $urandom_range(0, 15);
            run_op(o, a, b, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle controller for unsigned MULTU/DIVU in the MIPS pipeline. It reuses the shared 32-bit ALU: each cycle it drives the ALU operands and alu_control, and consumes the ALU result. Multiplication is shift-add and division is restoring, with two ALU cycles per bit. It owns the architectural HI/LO registers and supplies busy for the pipeline stall logic.

## Interface
- No parameters. Width is fixed at 32 and the iteration count at 32.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  launch an operation; sampled only in IDLE
- op  in  1  0 = MULTU, 1 = DIVU; sampled with start
- src_a  in  32  multiplicand or dividend (rs)
- src_b  in  32  multiplier or divisor (rt)
- cancel  in  1  abort from pipeline flush
- hi_we, lo_we  in  1  MTHI/MTLO write enables; honoured only in IDLE
- wdata  in  32  MTHI/MTLO data
- alu_a, alu_b  out  32  ALU operands
- alu_control  out  3  ALU op: 000 add, 001 sub, 100 unsigned less-than
- alu_result  in  32  combinational ALU result for the current cycle
- busy  out  1  high in STEP_A and STEP_B
- done  out  1  one-cycle pulse in DONE
- hi, lo  out  32  architectural HI/LO registers

## Operation
- States: IDLE, STEP_A, STEP_B, DONE. Reset puts the block in IDLE with hi = lo = 0, busy = done = 0, and all internal registers cleared.
- IDLE:
  - If start is high and cancel is low, latch op, M = src_a, P_hi = 0, P_lo = src_b (MULTU) or src_a (DIVU), D = src_b, cnt = 0, then go to STEP_A.
  - hi_we / lo_we load wdata into hi / lo. This applies even in the start cycle, but the loaded value is overwritten at commit.
- MULTU iteration (P = {P_hi, P_lo}):
  - STEP_A: alu_a = P_hi, alu_b = P_lo[0] ? M : 0, alu_control = 000. Latch T = alu_result.
  - STEP_B: alu_a = T, alu_b = P_hi, alu_control = 100. Compute c = alu_result[0] (carry out). Update P_hi <= {c, T[31:1]}, P_lo <= {T[0], P_lo[31:1]}.
- DIVU iteration:
  - Define Rs = {P_hi[30:0], P_lo[31]} and m = P_hi[31].
  - STEP_A: alu_a = Rs, alu_b = D, alu_control = 100. Latch ge = m | ~alu_result[0].
  - STEP_B: alu_a = Rs, alu_b = ge ? D : 0, alu_control = 001. Update P_hi <= alu_result, P_lo <= {P_lo[30:0], ge}.
- Every STEP_B increments cnt. If cnt was 31, commit hi <= P_hi_next and lo <= P_lo_next, then go to DONE. Otherwise go back to STEP_A.
- Results:
  - MULTU: {hi, lo} = src_a × src_b, full 64 bits.
  - DIVU: lo = quotient, hi = remainder.
- Divide by zero is defined as lo = 0xFFFFFFFF, hi = dividend. This falls out of the algorithm with no special case.
- DONE: done = 1 for one cycle, then IDLE unconditionally. start, hi_we, lo_we and cancel are all ignored in DONE.
- In IDLE and DONE, alu_a = alu_b = 0 and alu_control = 000.
- cancel in STEP_A or STEP_B: go to IDLE at the next edge. hi and lo stay unchanged and done is not asserted.
- start and cancel together in IDLE: cancel wins and no operation launches.
- start while busy, and hi_we / lo_we while busy, are ignored.
- Asynchronous rst at any point, including mid-operation: immediate return to the reset state with hi = lo = 0.

## Timing
- Edge E0 samples start in IDLE.
- Cycles 1..64 alternate STEP_A (odd) and STEP_B (even), with busy = 1.
- Edge E64 commits hi/lo. Cycle 65 is DONE, with done = 1, busy = 0, and the new hi/lo visible.
- Cycle 66 is IDLE. The earliest next start is sampled at the end of cycle 66.
- Total latency from start to done is 65 cycles, identical for both ops and independent of operand values.
- busy is a registered state decode with no combinational path from start. The pipeline must derive its stall on the start cycle itself.
- The ALU path is combinational within one cycle: the outputs alu_a/alu_b/alu_control feed the ALU, and the result returns on alu_result. T, ge, P_hi and P_lo are registered at the end of each step.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001; done exactly in cycle 65; busy high for cycles 1..64 only.
- DIVU 100 / 7 → lo = 14, hi = 2. DIVU 0x80000001 / 0x80000000 → lo = 1, hi = 1, which exercises the m = 1 path.
- DIVU 0x12345678 / 0 → lo = 0xFFFFFFFF, hi = 0x12345678.
- MTHI 0xAAAA5555 in IDLE, then MULTU 3 × 5 with cancel in cycle 10 → busy low from cycle 11, no done, hi = 0xAAAA5555, lo unchanged.
- During MULTU 6 × 7, pulse start (op = DIVU) and lo_we in cycle 20 → both ignored; result hi = 0, lo = 42.
- Assert rst in cycle 30 of DIVU → hi = lo = 0, state IDLE, busy = done = 0 immediately. A new MULTU 2 × 3 afterwards completes with lo = 6.
